// File: rtl/dilithium_pkg.sv
// rtl/dilithium_pkg.sv - shared Dilithium parameters and loader state encoding
package dilithium_pkg;

   localparam int N                   = 256;
   localparam int ETA                 = 4;
   localparam int POLYETA_PACKEDBYTES = 128;
   localparam int POLYETA_PACKED_W    = 8 * POLYETA_PACKEDBYTES;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_HOLD = 1'b1
   } load_state_t;

endpackage

// File: rtl/polyeta_nibble_chk.sv
// rtl/polyeta_nibble_chk.sv - flags any 4-bit field of a beat above the eta bound
module polyeta_nibble_chk #(
   parameter int W = 64
) (
   input  logic [W-1:0] data,
   input  logic [3:0]   bound,
   output logic         bad
);

   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < W / 4; i++) begin
         if (data[4*i +: 4] > bound) bad = 1'b1;
      end
   end

endmodule

// File: rtl/polyeta_load.sv
// rtl/polyeta_load.sv - assembles one eta-packed polynomial from a beat stream and screens it
module polyeta_load #(
   parameter int W_IN = 64,
   parameter int ETA  = dilithium_pkg::ETA
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       in_valid,
   output logic                                       in_ready,
   input  logic [W_IN-1:0]                            in_data,
   input  logic                                       in_last,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [dilithium_pkg::POLYETA_PACKED_W-1:0] out_data,
   output logic [1:0]                                 out_err
);
   import dilithium_pkg::*;

   localparam int               BEATS    = POLYETA_PACKED_W / W_IN;
   localparam int               CNT_W    = $clog2(BEATS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);
   localparam logic [3:0]       BOUND    = 4'(2 * ETA);

   load_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       err_q;
   logic             accept;
   logic             at_last;
   logic             range_bad;
   logic             frame_bad;

   polyeta_nibble_chk #(.W(W_IN)) u_nibble_chk (
      .data  (in_data),
      .bound (BOUND),
      .bad   (range_bad)
   );

   // Ready is gated by rst_n so it reads 0 for the whole reset interval.
   assign in_ready  = rst_n && (state_q == ST_FILL);
   assign out_valid = (state_q == ST_HOLD);
   assign out_err   = err_q;

   assign accept    = in_valid && in_ready;
   assign at_last   = (cnt_q == LAST_CNT);
   // The frame closes on the count; in_last is only compared against it.
   assign frame_bad = in_last ^ at_last;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL: if (accept && at_last) state_d = ST_HOLD;
         ST_HOLD: if (out_ready)         state_d = ST_FILL;
         default:                        state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_FILL;
         cnt_q    <= '0;
         err_q    <= '0;
         out_data <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            out_data[W_IN*cnt_q +: W_IN] <= in_data;
            cnt_q <= at_last ? '0 : cnt_q + CNT_W'(1);
            err_q <= err_q | {frame_bad, range_bad};
         end else if ((state_q == ST_HOLD) && out_ready) begin
            err_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_polyeta_load.sv
// tb/tb_polyeta_load.sv - self-checking bench for polyeta_load
module tb_polyeta_load;
   import dilithium_pkg::*;

   localparam int W     = 64;
   localparam int BEATS = 1024 / W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [1023:0] out_data;
   logic [1:0]    out_err;

   polyeta_load #(.W_IN(W), .ETA(ETA)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc++;

   logic [W-1:0]     words [BEATS];
   logic [BEATS-1:0] last_mask;
   logic [1023:0]    exp_q [$];
   logic [1:0]       experr_q [$];
   int               rise_q [$];
   logic [1023:0]    held;
   bit               prev_valid = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_data(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
      int idx;
      idx = 0;
      for (int j = 127; j >= 0; j--) if (obs[8*j +: 8] !== exp[8*j +: 8]) idx = j;
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s byte %0d observed=%h expected=%h", tag, idx, obs[8*idx +: 8], exp[8*idx +: 8]);
      end
   endtask

   // Reference: the polynomial is the beats laid end to end; errors follow the screening rules.
   function automatic logic [1023:0] model_data();
      logic [1023:0] d;
      for (int i = 0; i < BEATS; i++) d[W*i +: W] = words[i];
      return d;
   endfunction

   function automatic logic [1:0] model_err();
      logic r, f;
      r = 1'b0;
      f = 1'b0;
      for (int i = 0; i < BEATS; i++) begin
         for (int k = 0; k < W / 4; k++) if (int'(words[i][4*k +: 4]) > 2 * ETA) r = 1'b1;
         if (last_mask[i] != (i == BEATS - 1)) f = 1'b1;
      end
      return {f, r};
   endfunction

   task automatic gen_words(input int mode);
      for (int i = 0; i < BEATS; i++)
         for (int k = 0; k < W / 4; k++)
            if (mode != 0 && $urandom_range(19) == 0) words[i][4*k +: 4] = 4'($urandom_range(15, 9));
            else                                       words[i][4*k +: 4] = 4'($urandom_range(8));
   endtask

   task automatic push_expected();
      exp_q.push_back(model_data());
      experr_q.push_back(model_err());
   endtask

   task automatic drive_frame(input int nbeats, input int gap_pct);
      int beat;
      int guard;
      beat  = 0;
      guard = 0;
      while (beat < nbeats && guard < 1000) begin
         @(negedge clk);
         guard++;
         in_data  = words[beat];
         in_last  = last_mask[beat];
         in_valid = ($urandom_range(99) >= gap_pct);
         if (in_valid && in_ready) beat++;
      end
      check("drive_beats", 64'(beat), 64'(nbeats));
   endtask

   task automatic wait_valid();
      int g;
      g = 0;
      while (!out_valid && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("valid_timeout", 64'(out_valid), 64'd1);
   endtask

   task automatic release_frame();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic wait_drained();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(negedge clk);
         g++;
      end
      check("drained", 64'(exp_q.size()), 64'd0);
   endtask

   // Checks every presented polynomial against the head of the expected queue.
   always begin
      @(negedge clk);
      #2;
      if (rst_n && out_valid) begin
         if (!prev_valid) begin
            rise_q.push_back(cyc);
            check("frame_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               check_data("frame_data", out_data, exp_q[0]);
               check("frame_err", 64'(out_err), 64'(experr_q[0]));
            end
            held = out_data;
         end else begin
            check_data("hold_stable", out_data, held);
         end
         check("ready_in_hold", 64'(in_ready), 64'd0);
         if (out_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(experr_q.pop_front());
         end
      end
      prev_valid = rst_n && out_valid;
   end

   initial begin
      int nz;
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_err", 64'(out_err), 64'd0);
      check_data("rst_out_data", out_data, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 64'(in_ready), 64'd1);

      // Clean frame of eta-centred nibbles
      for (int i = 0; i < BEATS; i++) words[i] = 64'h4444_4444_4444_4444;
      last_mask = 16'h8000;
      push_expected();
      drive_frame(BEATS, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check("latency_valid", 64'(out_valid), 64'd1);
      wait_valid();
      nz = 0;
      for (int k = 0; k < 256; k++) if (ETA - int'(out_data[4*k +: 4]) != 0) nz++;
      check("unpack_zero", 64'(nz), 64'd0);
      check("clean_err", 64'(out_err), 64'd0);
      release_frame();

      // Range error in beat 3 byte 0
      for (int i = 0; i < BEATS; i++) words[i] = '0;
      words[3][7:0] = 8'h9F;
      push_expected();
      drive_frame(BEATS, 0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid();
      check("range_byte", 64'(out_data[199:192]), 64'h9F);
      check("range_err", 64'(out_err), 64'b01);
      release_frame();

      // Early in_last on beat 7, none on beat 15
      gen_words(0);
      last_mask = 16'h0080;
      push_expected();
      drive_frame(BEATS, 0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid();
      check("frame_err_bits", 64'(out_err), 64'b10);
      release_frame();

      // Backpressure with gaps and a long hold while a beat is offered
      for (int f = 0; f < 3; f++) begin
         gen_words(1);
         last_mask = 16'h8000;
         push_expected();
         drive_frame(BEATS, 40);
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = {W{1'b1}};
         in_last  = 1'b1;
         wait_valid();
         repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
         end
         out_ready = 1'b1;
         @(negedge clk);
         out_ready = 1'b0;
         in_valid  = 1'b0;
         in_last   = 1'b0;
      end

      // Back-to-back throughput with an incrementing byte pattern
      wait_drained();
      rise_q.delete();
      out_ready = 1'b1;
      for (int f = 0; f < 3; f++) begin
         for (int j = 0; j < 128; j++) begin
            words[j / 8][8*(j % 8) +: 8] = {4'((((j + f) >> 4) & 15) % 9), 4'(((j + f) & 15) % 9)};
         end
         last_mask = 16'h8000;
         push_expected();
         drive_frame(BEATS, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_drained();
      out_ready = 1'b0;
      check("tp_frames", 64'(rise_q.size()), 64'd3);
      if (rise_q.size() == 3) begin
         check("tp_period_1", 64'(rise_q[1] - rise_q[0]), 64'd17);
         check("tp_period_2", 64'(rise_q[2] - rise_q[1]), 64'd17);
      end

      // Mid-frame reset after beat 9, carrying an illegal beat
      gen_words(1);
      words[2] = {W{1'b1}};
      last_mask = 16'h0001;
      drive_frame(10, 0);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("mr_in_ready", 64'(in_ready), 64'd0);
      check("mr_out_valid", 64'(out_valid), 64'd0);
      check("mr_out_err", 64'(out_err), 64'd0);
      check_data("mr_out_data", out_data, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mr_ready_back", 64'(in_ready), 64'd1);
      gen_words(0);
      last_mask = 16'h8000;
      push_expected();
      drive_frame(BEATS, 0);
      @(negedge clk);
      in_valid = 1'b0;
      wait_valid();
      check("mr_no_residual", 64'(out_err), 64'd0);
      release_frame();

      // Random frames with random gaps, framing and hold lengths
      for (int f = 0; f < 6; f++) begin
         gen_words(1);
         last_mask = ($urandom_range(3) == 0) ? 16'($urandom) : 16'h8000;
         push_expected();
         drive_frame(BEATS, 25);
         @(negedge clk);
         in_valid = 1'b0;
         wait_valid();
         repeat ($urandom_range(3)) @(negedge clk);
         release_frame();
      end
      wait_drained();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
